cache_arbiter: RTL

- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) of the pipelined RV32I core.
- Sits below both caches, so `inst_*`/`data_*` misses from the pipeline datapath's caches become whole-line transfers on one `pmem_*` port.
- A 3-state FSM grants one requester at a time, latches its request and forwards the completion back.
- Ties are broken round-robin.

---
 rtl/rv32i_types.sv | 18 +
 rtl/rr_grant.sv | 24 ++
 rtl/cache_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I core; this slice carries the cache arbiter's
// FSM state, grant encoding and the cacheline width.
package rv32i_types;

  localparam int CACHELINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/rr_grant.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// A tie goes to whichever side was not granted last.
module rr_grant
  import rv32i_types::*;
(
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  arb_grant_t i_last_grant,
  output logic       o_valid,
  output arb_grant_t o_grant
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_valid = i_req_i | i_req_d;
    o_grant = GRANT_I;
    if (i_req_i && i_req_d) begin
      o_grant = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_req_d) begin
      o_grant = GRANT_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// One requester is granted at a time; its request is latched and run to pmem_resp.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH  = CACHELINE_WIDTH,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            r_state;
  arb_grant_t            r_last_grant;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [LINE_WIDTH-1:0] r_req_wdata;
  logic                  r_req_write;

  logic       w_req_d;
  logic       w_grant_valid;
  arb_grant_t w_grant;
  logic       w_busy;

  // A simultaneous read and write from the D-cache is treated as a write.
  assign w_req_d = d_read | d_write;

  rr_grant u_rr_grant (
    .i_req_i      (i_read),
    .i_req_d      (w_req_d),
    .i_last_grant (r_last_grant),
    .o_valid      (w_grant_valid),
    .o_grant      (w_grant)
  );

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_D;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_req_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant;
            if (w_grant == GRANT_I) begin
              r_state     <= I_BUSY;
              r_req_addr  <= {i_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              r_req_write <= 1'b0;
            end else begin
              r_state     <= D_BUSY;
              r_req_addr  <= {d_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              r_req_wdata <= d_wdata;
              r_req_write <= d_write;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy     = (r_state != IDLE);
  assign pmem_read  = w_busy & ~r_req_write;
  assign pmem_write = w_busy &  r_req_write;
  assign pmem_addr  = r_req_addr;
  assign pmem_wdata = r_req_wdata;

  // Completion is forwarded in the same cycle; pmem_resp while idle is dropped.
  assign i_resp  = (r_state == I_BUSY) & pmem_resp;
  assign d_resp  = (r_state == D_BUSY) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
